put_in_order: RTL and testbench

- Reorder buffer that collects results from n_inputs parallel units and emits them strictly in round-robin index order 0, 1, …, n_inputs-1, 0, …
- Work item k is issued to unit k mod n_inputs. Units return results with arbitrary, independent latency on their own lane of up_vlds/up_data.
- The block re-serialises these results into one in-order stream, down_vld/down_data.
- There is no backpressure in either direction.

---
 rtl/put_in_order.sv | 92 +++++++++
 tb/tb_put_in_order.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/put_in_order.sv
// rtl/put_in_order.sv - reorder buffer re-serialising n_inputs result lanes in round-robin order
//
// Purpose:
//   Work item k goes to unit k mod n_inputs. Units answer on their own lane
//   with any latency. This block holds early results and emits every item in
//   lane order 0, 1, ..., n_inputs-1, 0, ... on a single output stream.
//   There is no backpressure in either direction.
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst        asynchronous active-low reset
//   up_vlds    per-lane valid, one-cycle pulse per delivered result
//   up_data    per-lane data, meaningful only where up_vlds is set
//   down_vld   registered output valid, one pulse per emitted item
//   down_data  registered output data, holds its value between pulses

`timescale 1ns/1ps

module put_in_order #(
  parameter int width    = 8,
  parameter int n_inputs = 10
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [n_inputs-1:0]                up_vlds,
  input  logic [n_inputs-1:0][width-1:0]     up_data,
  output logic                               down_vld,
  output logic [width-1:0]                   down_data
);

  localparam int ptr_w = $clog2(n_inputs);
  typedef logic [ptr_w-1:0] ptr_t;

  logic [n_inputs-1:0] buf_vld;
  logic [n_inputs-1:0] buf_vld_nxt;
  logic [n_inputs-1:0] capture;
  logic [width-1:0]    buf_data [n_inputs];
  ptr_t                out_ptr;

  logic                from_buf;
  logic                bypass;
  logic                emit;
  logic [width-1:0]    emit_data;

  // The lane under out_ptr is served from its buffer first; only when that
  // buffer is empty can a fresh arrival on that lane go straight out.
  always_comb begin
    from_buf  = buf_vld[out_ptr];
    bypass    = !from_buf && up_vlds[out_ptr];
    emit      = from_buf || bypass;
    emit_data = from_buf ? buf_data[out_ptr] : up_data[out_ptr];

    // Every arriving lane is stored except the one that leaves by bypass.
    capture = up_vlds;
    if (bypass) begin
      capture[out_ptr] = 1'b0;
    end

    // Clear before set: a new arrival on the draining lane keeps its slot.
    buf_vld_nxt = buf_vld;
    if (from_buf) begin
      buf_vld_nxt[out_ptr] = 1'b0;
    end
    buf_vld_nxt = buf_vld_nxt | capture;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buf_vld   <= '0;
      out_ptr   <= '0;
      down_vld  <= 1'b0;
      down_data <= '0;
    end else begin
      buf_vld  <= buf_vld_nxt;
      down_vld <= emit;
      if (emit) begin
        down_data <= emit_data;
        out_ptr   <= (out_ptr == ptr_t'(n_inputs - 1)) ? '0 : out_ptr + ptr_t'(1);
      end
    end
  end

  // Data storage is qualified by buf_vld, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < n_inputs; i++) begin
      if (capture[i]) begin
        buf_data[i] <= up_data[i];
      end
    end
  end

endmodule

// File: tb/tb_put_in_order.sv
// tb/tb_put_in_order.sv - self-checking bench for put_in_order with an in-order scoreboard

`timescale 1ns/1ps

module tb_put_in_order;

  localparam int W = 8;
  localparam int N = 10;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [N-1:0]        up_vlds = '0;
  logic [N-1:0][W-1:0] up_data = '0;
  logic                down_vld;
  logic [W-1:0]        down_data;

  put_in_order #(.width(W), .n_inputs(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .up_vlds   (up_vlds),
    .up_data   (up_data),
    .down_vld  (down_vld),
    .down_data (down_data)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [W-1:0] exp_q[$];
  int         issued  = 0;
  int         emitted = 0;

  bit           lane_pend [N];
  int           lane_cnt  [N];
  logic [W-1:0] lane_dat  [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every output pulse must match the oldest issued item.
  always @(negedge clk) begin
    if (rst && down_vld) begin
      if (exp_q.size() == 0) begin
        chk("down_vld_unexpected", {31'b0, down_vld}, 32'd0);
      end else begin
        chk("down_data", {24'b0, down_data}, {24'b0, exp_q.pop_front()});
        emitted++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    issued  = 0;
    emitted = 0;
    for (int i = 0; i < N; i++) lane_pend[i] = 1'b0;
  endtask

  task automatic do_reset();
    rst     = 1'b0;
    up_vlds = '0;
    clear_model();
    #1;
    chk("reset_down_vld", {31'b0, down_vld}, 32'd0);
    chk("reset_down_data", {24'b0, down_data}, 32'd0);
    step();
    step();
    rst = 1'b1;
  endtask

  function automatic bit any_pending();
    for (int i = 0; i < N; i++) if (lane_pend[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run_random(input int nitems, input bit seq_data);
    int done   = 0;
    int budget = 0;
    int ln;
    while ((done < nitems || any_pending()) && budget < 20000) begin
      up_vlds = '0;
      for (int i = 0; i < N; i++) up_data[i] = W'($urandom);
      if (done < nitems && $urandom_range(99) < 80 && (issued - emitted) < N) begin
        ln            = issued % N;
        lane_pend[ln] = 1'b1;
        lane_cnt[ln]  = $urandom_range(9);
        lane_dat[ln]  = seq_data ? W'(issued) : W'($urandom);
        exp_q.push_back(lane_dat[ln]);
        issued++;
        done++;
      end
      for (int i = 0; i < N; i++) begin
        if (lane_pend[i]) begin
          if (lane_cnt[i] == 0) begin
            up_vlds[i]   = 1'b1;
            up_data[i]   = lane_dat[i];
            lane_pend[i] = 1'b0;
          end else begin
            lane_cnt[i]--;
          end
        end
      end
      step();
      budget++;
    end
    up_vlds = '0;
    budget  = 0;
    while (exp_q.size() != 0 && budget < 200) begin
      step();
      budget++;
    end
    chk("random_drain_left", exp_q.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  initial begin
    step();
    do_reset();

    // In-order single items
    exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    issued = 3;
    up_vlds = 10'b0000000001; up_data[0] = 8'h00;
    step(); chk("inorder_vld0", {31'b0, down_vld}, 32'd1);
    up_vlds = 10'b0000000010; up_data[1] = 8'h01;
    step(); chk("inorder_vld1", {31'b0, down_vld}, 32'd1);
    up_vlds = 10'b0000000100; up_data[2] = 8'h02;
    step(); chk("inorder_vld2", {31'b0, down_vld}, 32'd1);
    up_vlds = '0;
    step(); chk("inorder_idle", {31'b0, down_vld}, 32'd0);

    // Reversed arrival
    do_reset();
    exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'h02);
    issued = 3;
    up_vlds = 10'b0000000100; up_data[2] = 8'h02;
    step(); chk("rev_t1_quiet", {31'b0, down_vld}, 32'd0);
    up_vlds = 10'b0000000010; up_data[1] = 8'h01;
    step(); chk("rev_t2_quiet", {31'b0, down_vld}, 32'd0);
    up_vlds = 10'b0000000001; up_data[0] = 8'h00;
    step(); chk("rev_t3_vld", {31'b0, down_vld}, 32'd1);
    up_vlds = '0;
    step(); chk("rev_t4_vld", {31'b0, down_vld}, 32'd1);
    step(); chk("rev_t5_vld", {31'b0, down_vld}, 32'd1);
    step(); chk("rev_t6_quiet", {31'b0, down_vld}, 32'd0);

    // Burst on all lanes
    do_reset();
    for (int i = 0; i < N; i++) begin
      up_data[i] = W'(8'h0A + i);
      exp_q.push_back(W'(8'h0A + i));
    end
    issued  = N;
    up_vlds = '1;
    step();
    up_vlds = '0;
    chk("burst_vld_0", {31'b0, down_vld}, 32'd1);
    for (int i = 1; i < N; i++) begin
      step();
      chk($sformatf("burst_vld_%0d", i), {31'b0, down_vld}, 32'd1);
    end
    step(); chk("burst_end_quiet", {31'b0, down_vld}, 32'd0);
    exp_q.push_back(8'h77);
    issued++;
    up_vlds = 10'b0000000001; up_data[0] = 8'h77;
    step(); chk("burst_ptr_wrapped", {31'b0, down_vld}, 32'd1);
    up_vlds = '0;
    step(); chk("burst_after_quiet", {31'b0, down_vld}, 32'd0);

    // Wrap-around with sequential data, then random stress
    do_reset();
    run_random(30, 1'b1);
    run_random(1000, 1'b0);
    for (int i = 0; i < 10; i++) step();
    chk("stress_idle_vld", {31'b0, down_vld}, 32'd0);

    // Reset mid-stream with lanes 3..5 buffered
    do_reset();
    up_vlds = 10'b0000111000;
    up_data[3] = 8'hA3; up_data[4] = 8'hA4; up_data[5] = 8'hA5;
    step();
    exp_q.push_back(8'h10);
    issued  = 1;
    up_vlds = 10'b0000000001; up_data[0] = 8'h10;
    step();
    up_vlds = '0;
    chk("pre_reset_vld", {31'b0, down_vld}, 32'd1);
    rst = 1'b0;
    #1;
    chk("async_reset_vld", {31'b0, down_vld}, 32'd0);
    chk("async_reset_data", {24'b0, down_data}, 32'd0);
    clear_model();
    step();
    rst = 1'b1;
    exp_q.push_back(8'h55);
    issued  = 1;
    up_vlds = 10'b0000000001; up_data[0] = 8'h55;
    step(); chk("post_reset_vld", {31'b0, down_vld}, 32'd1);
    exp_q.push_back(8'h56); exp_q.push_back(8'h57);
    issued  = 3;
    up_vlds = 10'b0000000110; up_data[1] = 8'h56; up_data[2] = 8'h57;
    step(); chk("post_reset_vld1", {31'b0, down_vld}, 32'd1);
    up_vlds = '0;
    step(); chk("post_reset_vld2", {31'b0, down_vld}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("discarded_quiet_%0d", i), {31'b0, down_vld}, 32'd0);
    end
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
